// File: rtl/leddc_tx.sv
// leddc_tx: serializes 16-bit pixel words LSB-first on DAI with DEN framing each word,
// counting committed words within a frame and flagging start-of-frame misalignment.
module leddc_tx #(
    parameter int GAP         = 1,
    parameter int FRAME_WORDS = 512
) (
    input  logic        DCK,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_sof,
    output logic        in_ready,
    output logic        DAI,
    output logic        DEN,
    output logic [8:0]  word_cnt,
    output logic        frame_done,
    output logic        sync_err,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);
    localparam logic [8:0] WORD_LAST = 9'(FRAME_WORDS - 1);

    state_e      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        dai_q, dai_d;
    logic        den_q, den_d;
    logic [8:0]  word_cnt_q, word_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        sync_err_q, sync_err_d;
    logic        accept;
    logic        last_bit;
    logic        gap_last;

    assign last_bit = (bit_cnt_q == 4'd15);
    assign gap_last = (gap_cnt_q == GAP_LAST);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge DCK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each always_comb assigns defaults first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_GAP;
            S_GAP:   if (gap_last) state_d = accept ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is withheld while rst is high so nothing is offered to a source during reset.
    always_comb begin
        in_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_GAP) && gap_last));
        accept   = in_valid && in_ready;
        busy     = (state_q != S_IDLE);
    end

    // shreg holds the bits not yet driven; bit 0 is the next one to appear on DAI.
    always_comb begin
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        dai_d        = 1'b0;
        den_d        = 1'b0;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        sync_err_d   = sync_err_q;
        if (accept) begin
            shreg_d   = {1'b0, in_data[15:1]};
            bit_cnt_d = 4'd0;
            dai_d     = in_data[0];
            den_d     = 1'b1;
            if (in_sof && (word_cnt_q != 9'd0)) begin
                sync_err_d = 1'b1;
                word_cnt_d = 9'd0;
            end
        end else if (state_q == S_SHIFT) begin
            if (last_bit) begin
                gap_cnt_d = 4'd0;
                if (word_cnt_q == WORD_LAST) begin
                    word_cnt_d   = 9'd0;
                    frame_done_d = 1'b1;
                end else begin
                    word_cnt_d = word_cnt_q + 9'd1;
                end
            end else begin
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + 4'd1;
                dai_d     = shreg_q[0];
                den_d     = 1'b1;
            end
        end else if ((state_q == S_GAP) && !gap_last) begin
            gap_cnt_d = gap_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge DCK or posedge rst) begin
        if (rst) begin
            shreg_q      <= 16'd0;
            bit_cnt_q    <= 4'd0;
            gap_cnt_q    <= 4'd0;
            dai_q        <= 1'b0;
            den_q        <= 1'b0;
            word_cnt_q   <= 9'd0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            dai_q        <= dai_d;
            den_q        <= den_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign DAI        = dai_q;
    assign DEN        = den_q;
    assign word_cnt   = word_cnt_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_leddc_tx.sv
// Directed bench for leddc_tx: one instance with GAP=1 and one with GAP=4, each observed
// by a receiver that captures words on the DEN fall the way the display driver does.
module tb_leddc_tx;

    logic        DCK = 1'b0;
    logic        rst = 1'b1;

    logic        a_valid = 1'b0, a_sof = 1'b0;
    logic [15:0] a_data = 16'd0;
    logic        a_ready, a_dai, a_den, a_fdone, a_serr, a_busy;
    logic [8:0]  a_wcnt;

    logic        b_valid = 1'b0, b_sof = 1'b0;
    logic [15:0] b_data = 16'd0;
    logic        b_ready, b_dai, b_den, b_fdone, b_serr, b_busy;
    logic [8:0]  b_wcnt;

    int total = 0;
    int bad   = 0;

    leddc_tx #(.GAP(1), .FRAME_WORDS(512)) dut_a (
        .DCK(DCK), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_sof(a_sof),
        .in_ready(a_ready), .DAI(a_dai), .DEN(a_den), .word_cnt(a_wcnt),
        .frame_done(a_fdone), .sync_err(a_serr), .busy(a_busy)
    );

    leddc_tx #(.GAP(4), .FRAME_WORDS(512)) dut_b (
        .DCK(DCK), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_sof(b_sof),
        .in_ready(b_ready), .DAI(b_dai), .DEN(b_den), .word_cnt(b_wcnt),
        .frame_done(b_fdone), .sync_err(b_serr), .busy(b_busy)
    );

    always #5 DCK = ~DCK;

    // Receiver for instance A: shifts in while DEN is high, commits on the DEN fall.
    logic [15:0] ra_sh = 16'd0;
    int          ra_bits = 0, ra_total = 0, fd_cnt = 0, fd_at = -1;
    logic        ra_prev = 1'b0;
    logic [15:0] ra_words[$];
    int          ra_lens[$];

    always @(negedge DCK) begin
        if (rst) begin
            ra_bits = 0;
            ra_prev = 1'b0;
        end else begin
            if (a_den) begin
                ra_sh = {a_dai, ra_sh[15:1]};
                ra_bits++;
            end else if (ra_prev) begin
                ra_words.push_back(ra_sh);
                ra_lens.push_back(ra_bits);
                ra_bits = 0;
                ra_total++;
            end
            if (a_fdone) begin
                fd_cnt++;
                fd_at = ra_total;
            end
            ra_prev = a_den;
        end
    end

    // Receiver for instance B also measures DEN-low runs between words.
    logic [15:0] rb_sh = 16'd0;
    logic        rb_prev = 1'b0, rb_seen = 1'b0;
    int          rb_low = 0, rb_min_low = 99;
    logic [15:0] rb_words[$];

    always @(negedge DCK) begin
        if (rst) begin
            rb_prev = 1'b0;
            rb_low  = 0;
        end else begin
            if (b_den) begin
                if (!rb_prev && rb_seen && rb_low < rb_min_low) rb_min_low = rb_low;
                rb_sh = {b_dai, rb_sh[15:1]};
            end else begin
                if (rb_prev) begin
                    rb_words.push_back(rb_sh);
                    rb_seen = 1'b1;
                    rb_low  = 0;
                end
                rb_low++;
            end
            rb_prev = b_den;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge DCK);
            #1;
        end
    endtask

    // Presents a word to A, waits (bounded) for in_ready, returns one step after acceptance.
    task automatic send_a(input logic [15:0] d, input logic sof);
        int n;
        n = 0;
        a_data  = d;
        a_sof   = sof;
        a_valid = 1'b1;
        while (a_ready !== 1'b1 && n < 64) begin
            step(1);
            n++;
        end
        total++;
        if (a_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: in_ready=%b after %0d cycles, expected 1", a_ready, n);
        end
        step(1);
        a_valid = 1'b0;
        a_sof   = 1'b0;
    endtask

    task automatic test_reset;
        total++;
        if ({a_den, a_dai, a_fdone, a_serr, a_busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: den,dai,fdone,serr,busy=%b expected 00000",
                     {a_den, a_dai, a_fdone, a_serr, a_busy});
        end
        total++;
        if (a_wcnt !== 9'd0) begin
            bad++;
            $display("FAIL reset_word_cnt: got %0d expected 0", a_wcnt);
        end
        total++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_low: a=%b b=%b expected 0 0", a_ready, b_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: a_ready=%b b_ready=%b busy=%b expected 1 1 0",
                     a_ready, b_ready, a_busy);
        end
    endtask

    task automatic test_single;
        logic [0:15] seq;
        seq = 16'b1100_0011_1010_0101;
        send_a(16'hA5C3, 1'b0);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (a_den !== 1'b1 || a_dai !== seq[i]) begin
                bad++;
                $display("FAIL single_bit%0d: den=%b dai=%b expected den=1 dai=%b",
                         i, a_den, a_dai, seq[i]);
            end
            if (i == 15) begin
                total++;
                if (a_ready !== 1'b0 || a_wcnt !== 9'd0 || a_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL single_midword: ready=%b word_cnt=%0d busy=%b expected 0 0 1",
                             a_ready, a_wcnt, a_busy);
                end
            end
            step(1);
        end
        total++;
        if (a_den !== 1'b0 || a_wcnt !== 9'd1 || a_ready !== 1'b1 || a_fdone !== 1'b0) begin
            bad++;
            $display("FAIL single_commit: den=%b word_cnt=%0d ready=%b fdone=%b expected 0 1 1 0",
                     a_den, a_wcnt, a_ready, a_fdone);
        end
        step(1);
        total++;
        if (a_busy !== 1'b0 || a_ready !== 1'b1 || a_den !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: busy=%b ready=%b den=%b expected 0 1 0",
                     a_busy, a_ready, a_den);
        end
    endtask

    task automatic test_back_to_back;
        logic [33:0] den_seq;
        logic [33:0] den_exp;
        den_exp = 34'b0_1111111111111111_0_1111111111111111;
        den_seq = '0;
        ra_words.delete();
        ra_lens.delete();
        send_a(16'h0001, 1'b0);
        a_data  = 16'h8000;
        a_valid = 1'b1;
        for (int c = 0; c < 34; c++) begin
            den_seq[c] = a_den;
            if (c == 16) begin
                total++;
                if (a_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready_in_gap: got %b expected 1", a_ready);
                end
            end
            if (c == 17) a_valid = 1'b0;
            step(1);
        end
        total++;
        if (den_seq !== den_exp) begin
            bad++;
            $display("FAIL b2b_den_pattern: got %b expected %b", den_seq, den_exp);
        end
        total++;
        if (ra_words.size() != 2) begin
            bad++;
            $display("FAIL b2b_word_count: got %0d expected 2", ra_words.size());
        end else if (ra_words[0] !== 16'h0001 || ra_words[1] !== 16'h8000) begin
            bad++;
            $display("FAIL b2b_words: got %h %h expected 0001 8000", ra_words[0], ra_words[1]);
        end
        total++;
        if (a_wcnt !== 9'd3) begin
            bad++;
            $display("FAIL b2b_word_cnt: got %0d expected 3", a_wcnt);
        end
    endtask

    task automatic test_frame;
        int base_fd, base_total, errs;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        ra_words.delete();
        ra_lens.delete();
        base_fd    = fd_cnt;
        base_total = ra_total;
        for (int i = 0; i < 512; i++) send_a(16'(i), 1'b0);
        step(20);
        total++;
        if (fd_cnt - base_fd != 1 || fd_at != base_total + 512) begin
            bad++;
            $display("FAIL frame_done: pulses=%0d at_commit=%0d expected 1 at %0d",
                     fd_cnt - base_fd, fd_at - base_total, 512);
        end
        total++;
        if (a_wcnt !== 9'd0 || a_serr !== 1'b0) begin
            bad++;
            $display("FAIL frame_wrap: word_cnt=%0d sync_err=%b expected 0 0", a_wcnt, a_serr);
        end
        errs = 0;
        if (ra_words.size() != 512) errs = 1;
        else for (int i = 0; i < 512; i++) if (ra_words[i] !== 16'(i)) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL frame_data: %0d bad words of %0d received, expected 0 bad of 512",
                     errs, ra_words.size());
        end
    endtask

    task automatic test_sof;
        send_a(16'h0F0F, 1'b1);
        step(16);
        total++;
        if (a_serr !== 1'b0 || a_wcnt !== 9'd1) begin
            bad++;
            $display("FAIL sof_clean: sync_err=%b word_cnt=%0d expected 0 1", a_serr, a_wcnt);
        end
        for (int i = 0; i < 36; i++) send_a(16'h3000 + 16'(i), 1'b0);
        step(16);
        total++;
        if (a_wcnt !== 9'd37) begin
            bad++;
            $display("FAIL sof_pre_count: word_cnt=%0d expected 37", a_wcnt);
        end
        send_a(16'hDEAD, 1'b1);
        total++;
        if (a_serr !== 1'b1 || a_wcnt !== 9'd0) begin
            bad++;
            $display("FAIL sof_mismatch: sync_err=%b word_cnt=%0d expected 1 0", a_serr, a_wcnt);
        end
        step(16);
        total++;
        if (a_wcnt !== 9'd1 || a_fdone !== 1'b0) begin
            bad++;
            $display("FAIL sof_commit_as_0: word_cnt=%0d fdone=%b expected 1 0", a_wcnt, a_fdone);
        end
        send_a(16'h1111, 1'b0);
        step(16);
        total++;
        if (a_serr !== 1'b1 || a_wcnt !== 9'd2) begin
            bad++;
            $display("FAIL sof_sticky: sync_err=%b word_cnt=%0d expected 1 2", a_serr, a_wcnt);
        end
    endtask

    task automatic test_reset_mid;
        send_a(16'hBEEF, 1'b0);
        step(7);
        total++;
        if (a_den !== 1'b1 || a_dai !== 1'b1) begin
            bad++;
            $display("FAIL mid_bit7: den=%b dai=%b expected 1 1", a_den, a_dai);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({a_den, a_dai, a_ready, a_busy, a_serr} !== 5'b0 || a_wcnt !== 9'd0) begin
            bad++;
            $display("FAIL mid_async: den,dai,ready,busy,serr=%b word_cnt=%0d expected 00000 0",
                     {a_den, a_dai, a_ready, a_busy, a_serr}, a_wcnt);
        end
        step(1);
        total++;
        if (a_den !== 1'b0 || a_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_held: den=%b ready=%b expected 0 0", a_den, a_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (a_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_release: ready=%b expected 1", a_ready);
        end
        ra_words.delete();
        ra_lens.delete();
        send_a(16'h1234, 1'b0);
        step(17);
        total++;
        if (ra_words.size() != 1) begin
            bad++;
            $display("FAIL mid_next_count: got %0d words expected 1", ra_words.size());
        end else if (ra_words[0] !== 16'h1234 || ra_lens[0] != 16) begin
            bad++;
            $display("FAIL mid_next_word: got %h len %0d expected 1234 len 16",
                     ra_words[0], ra_lens[0]);
        end
        total++;
        if (a_wcnt !== 9'd1) begin
            bad++;
            $display("FAIL mid_word_cnt: got %0d expected 1", a_wcnt);
        end
    endtask

    task automatic test_gap4;
        logic [15:0] w[8];
        logic [31:0] vp;
        int          k, cyc, rise_err;
        logic        acc, acc_prev, prev_den, rise;
        w  = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1357, 16'h2468, 16'hA5A5, 16'h0F0F, 16'hC001};
        vp = 32'b1011_0111_1110_1101_1111_0011_1011_1111;
        rb_words.delete();
        k = 0; cyc = 0; rise_err = 0;
        acc_prev = 1'b0;
        prev_den = b_den;
        b_data   = w[0];
        while (k < 8 && cyc < 1000) begin
            rise = b_den && !prev_den;
            if (rise !== acc_prev) rise_err++;
            prev_den = b_den;
            b_valid  = vp[cyc % 32];
            acc      = b_valid && b_ready;
            acc_prev = acc;
            step(1);
            cyc++;
            if (acc) begin
                k++;
                if (k < 8) b_data = w[k];
            end
        end
        rise = b_den && !prev_den;
        if (rise !== acc_prev) rise_err++;
        b_valid = 1'b0;
        step(30);
        total++;
        if (k != 8) begin
            bad++;
            $display("FAIL gap4_accepts: got %0d within %0d cycles expected 8", k, cyc);
        end
        total++;
        if (rise_err != 0) begin
            bad++;
            $display("FAIL gap4_accept_vs_ready: %0d DEN starts disagreed with handshake, expected 0",
                     rise_err);
        end
        total++;
        if (rb_min_low < 4) begin
            bad++;
            $display("FAIL gap4_den_low: shortest run %0d expected >= 4", rb_min_low);
        end
        total++;
        if (rb_words.size() != 8) begin
            bad++;
            $display("FAIL gap4_count: got %0d words expected 8", rb_words.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (rb_words[i] !== w[i]) begin
                    bad++;
                    $display("FAIL gap4_order%0d: got %h expected %h", i, rb_words[i], w[i]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1);
        test_reset();
        test_single();
        test_back_to_back();
        test_frame();
        test_sof();
        test_reset_mid();
        test_gap4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
